// File: rtl/write_back_buffer_pkg.sv
// ============================================================================
// Module : write_back_buffer_pkg
// Purpose: Shared defaults, entry type and width helper for the write-back
//          buffer and its address CAM.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package write_back_buffer_pkg;

  localparam int WB_DATA_WIDTH = 32;
  localparam int WB_ADDR_WIDTH = 32;
  localparam int WB_DEPTH      = 4;
  localparam int WB_PTR_W      = $clog2(WB_DEPTH);

  // One buffer slot at the default geometry (word address drops bits [1:0]).
  typedef struct packed {
    logic                       valid;
    logic [WB_ADDR_WIDTH-3:0]   waddr;
    logic [WB_DATA_WIDTH-1:0]   data;
  } wb_entry_t;

  // Occupancy counter needs one extra bit so that "full" (== depth) is representable.
  function automatic int wb_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_addr_cam.sv
// ============================================================================
// Module : wb_addr_cam
// Purpose: Fully associative compare of one word address against all buffer
//          entries. Returns a one-hot match vector and the matched entry's
//          data (zero when nothing matches).
// Ports  : valid      in   per-entry valid bits
//          waddr      in   per-entry word addresses
//          data       in   per-entry data words
//          cmp_addr   in   word address to search for
//          match      out  one-hot (or zero) match vector
//          match_data out  data of the matching entry
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_addr_cam #(
  parameter int DEPTH = 4,
  parameter int AW    = 30,
  parameter int DW    = 32
) (
  input  logic [DEPTH-1:0]         valid,
  input  logic [DEPTH-1:0][AW-1:0] waddr,
  input  logic [DEPTH-1:0][DW-1:0] data,
  input  logic [AW-1:0]            cmp_addr,
  output logic [DEPTH-1:0]         match,
  output logic [DW-1:0]            match_data
);

  // The buffer coalesces pushes, so at most one bit of match is ever set;
  // an OR of masked data is therefore a correct mux.
  always_comb begin
    match      = '0;
    match_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = valid[i] && (waddr[i] == cmp_addr);
      if (match[i]) begin
        match_data = match_data | data[i];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/write_back_buffer.sv
// ============================================================================
// Module : write_back_buffer
// Purpose: Queues dirty-line evictions in a small circular FIFO, drains them
//          to RAM whenever the cache is not reading RAM, and forwards queued
//          data to miss fills so fills never observe stale RAM contents.
// Ports  : clk, rst                      clock, synchronous active-high reset
//          push_en/push_addr/push_data   eviction from the cache
//          full                          no free entry
//          lookup_en/lookup_addr/ram_rd  miss fill request and RAM read data
//          fill_data/fwd_hit             fill word and forward indication
//          ram_we/ram_addr/ram_wd        drain write request to RAM
//          ram_ready                     RAM accepts the drain write
//          overflow                      sticky: a push was dropped
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module write_back_buffer
  import write_back_buffer_pkg::*;
#(
  parameter int DATA_WIDTH     = WB_DATA_WIDTH,
  parameter int RAM_ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int DEPTH          = WB_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push_en,
  input  logic [RAM_ADDR_WIDTH-1:0] push_addr,
  input  logic [DATA_WIDTH-1:0]     push_data,
  output logic                      full,
  input  logic                      lookup_en,
  input  logic [RAM_ADDR_WIDTH-1:0] lookup_addr,
  input  logic [DATA_WIDTH-1:0]     ram_rd,
  output logic [DATA_WIDTH-1:0]     fill_data,
  output logic                      fwd_hit,
  output logic                      ram_we,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]     ram_wd,
  input  logic                      ram_ready,
  output logic                      overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = wb_cnt_w(DEPTH);
  localparam int WAW   = RAM_ADDR_WIDTH - 2;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  // Entry storage, kept as parallel arrays so the CAM can scan them directly.
  logic [DEPTH-1:0]                ent_valid;
  logic [DEPTH-1:0][WAW-1:0]       ent_waddr;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] ent_data;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             ovf;

  logic [DEPTH-1:0]      lookup_match;
  logic [DATA_WIDTH-1:0] lookup_data;
  logic [DEPTH-1:0]      push_match;
  logic [DATA_WIDTH-1:0] push_cam_data_unused;
  logic [3:0]            byte_off_unused;

  logic [DEPTH-1:0] head_onehot;
  logic [DEPTH-1:0] coalesce_vec;
  logic             pop;
  logic             coalesce;
  logic             alloc;
  logic             drop;

  assign byte_off_unused = {push_addr[1:0], lookup_addr[1:0]};

  wb_addr_cam #(
    .DEPTH (DEPTH),
    .AW    (WAW),
    .DW    (DATA_WIDTH)
  ) u_lookup_cam (
    .valid      (ent_valid),
    .waddr      (ent_waddr),
    .data       (ent_data),
    .cmp_addr   (lookup_addr[RAM_ADDR_WIDTH-1:2]),
    .match      (lookup_match),
    .match_data (lookup_data)
  );

  wb_addr_cam #(
    .DEPTH (DEPTH),
    .AW    (WAW),
    .DW    (DATA_WIDTH)
  ) u_push_cam (
    .valid      (ent_valid),
    .waddr      (ent_waddr),
    .data       (ent_data),
    .cmp_addr   (push_addr[RAM_ADDR_WIDTH-1:2]),
    .match      (push_match),
    .match_data (push_cam_data_unused)
  );

  // Drain request. The fill lookup owns the RAM port, and a reset cycle
  // must never leak a write of soon-to-be-discarded data.
  assign ram_we   = (count != '0) && !lookup_en && !rst;
  assign ram_addr = lookup_en ? lookup_addr : {ent_waddr[head], 2'b00};
  assign ram_wd   = ent_data[head];
  assign pop      = ram_we && ram_ready;

  assign fwd_hit   = lookup_en && (|lookup_match);
  assign fill_data = fwd_hit ? lookup_data : ram_rd;

  assign full     = (count == DEPTH_CNT);
  assign overflow = ovf;

  // A push hitting the entry that is leaving this cycle cannot be merged
  // into it (the RAM gets the old data); it becomes a fresh allocation.
  assign head_onehot  = DEPTH'(1) << head;
  assign coalesce_vec = push_match & ~(pop ? head_onehot : '0);
  assign coalesce     = push_en && (|coalesce_vec);
  assign alloc        = push_en && !coalesce && ((count != DEPTH_CNT) || pop);
  assign drop         = push_en && !coalesce && !alloc;

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_valid <= '0;
      ent_waddr <= '0;
      ent_data  <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ovf       <= 1'b0;
    end else begin
      if (pop) begin
        ent_valid[head] <= 1'b0;
        head            <= head + PTR_W'(1);
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (coalesce && coalesce_vec[i]) begin
          ent_data[i] <= push_data;
        end
      end
      // Placed after the pop so that, when full, a same-cycle alloc into the
      // slot being vacated (tail == head) leaves it valid.
      if (alloc) begin
        ent_valid[tail] <= 1'b1;
        ent_waddr[tail] <= push_addr[RAM_ADDR_WIDTH-1:2];
        ent_data[tail]  <= push_data;
        tail            <= tail + PTR_W'(1);
      end
      count <= count + CNT_W'(alloc) - CNT_W'(pop);
      if (drop) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_write_back_buffer.sv
// ============================================================================
// Module : tb_write_back_buffer
// Purpose: Directed self-checking bench for write_back_buffer. A queue-based
//          model predicts the outputs every cycle; directed literal checks
//          pin the model to hand-computed values.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_write_back_buffer;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          push_en;
  logic [AW-1:0] push_addr;
  logic [DW-1:0] push_data;
  logic          full;
  logic          lookup_en;
  logic [AW-1:0] lookup_addr;
  logic [DW-1:0] ram_rd;
  logic [DW-1:0] fill_data;
  logic          fwd_hit;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wd;
  logic          ram_ready;
  logic          overflow;

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 1'b0;

  write_back_buffer #(
    .DATA_WIDTH     (DW),
    .RAM_ADDR_WIDTH (AW),
    .DEPTH          (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .push_en     (push_en),
    .push_addr   (push_addr),
    .push_data   (push_data),
    .full        (full),
    .lookup_en   (lookup_en),
    .lookup_addr (lookup_addr),
    .ram_rd      (ram_rd),
    .fill_data   (fill_data),
    .fwd_hit     (fwd_hit),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wd      (ram_wd),
    .ram_ready   (ram_ready),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: ordered list of queued words ----------
  logic [AW-3:0] q_addr[$];
  logic [DW-1:0] q_data[$];
  bit            m_ovf;

  function automatic bit m_we();
    return (q_addr.size() != 0) && !lookup_en && !rst;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      q_addr.delete();
      q_data.delete();
      m_ovf = 1'b0;
    end else begin
      bit popping;
      int hit_idx;
      popping = m_we() && ram_ready;
      hit_idx = -1;
      if (push_en) begin
        foreach (q_addr[i]) begin
          if (q_addr[i] == push_addr[AW-1:2] && !(popping && i == 0)) hit_idx = i;
        end
        if (hit_idx >= 0) q_data[hit_idx] = push_data;
      end
      if (popping) begin
        void'(q_addr.pop_front());
        void'(q_data.pop_front());
      end
      if (push_en && hit_idx < 0) begin
        if (q_addr.size() < DEPTH) begin
          q_addr.push_back(push_addr[AW-1:2]);
          q_data.push_back(push_data);
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  end

  // ---------------- per-cycle comparison against the model -----------------
  always @(negedge clk) begin
    if (started) begin
      bit            e_hit;
      logic [DW-1:0] e_fill;
      e_hit  = 1'b0;
      e_fill = ram_rd;
      if (lookup_en) begin
        foreach (q_addr[i]) begin
          if (q_addr[i] == lookup_addr[AW-1:2]) begin
            e_hit  = 1'b1;
            e_fill = q_data[i];
          end
        end
      end
      chk("model_full", {31'd0, full}, {31'd0, q_addr.size() == DEPTH});
      chk("model_ram_we", {31'd0, ram_we}, {31'd0, m_we()});
      chk("model_overflow", {31'd0, overflow}, {31'd0, m_ovf});
      chk("model_fwd_hit", {31'd0, fwd_hit}, {31'd0, e_hit});
      chk("model_fill_data", fill_data, e_fill);
      if (lookup_en) chk("model_ram_addr_lookup", ram_addr, lookup_addr);
      if (m_we()) begin
        chk("model_ram_addr_drain", ram_addr, {q_addr[0], 2'b00});
        chk("model_ram_wd", ram_wd, q_data[0]);
      end
    end
  end

  // ---------------- stimulus helpers ---------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    push_en   = 1'b1;
    push_addr = a;
    push_data = d;
    tick();
    push_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; push_en = 1'b0; push_addr = '0; push_data = '0;
    lookup_en = 1'b0; lookup_addr = '0; ram_rd = '0; ram_ready = 1'b0;
    tick();
    started = 1'b1;
    tick();
    rst = 1'b0;

    // 1: idle after reset
    ram_rd = 32'h5555_1234;
    settle();
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_fwd_hit", {31'd0, fwd_hit}, 32'd0);
    chk("rst_fill_data", fill_data, 32'h5555_1234);
    tick();

    // 2: single push then drain
    ram_ready = 1'b1;
    push(32'h100, 32'hAAAA);
    settle();
    chk("t2_ram_we", {31'd0, ram_we}, 32'd1);
    chk("t2_ram_addr", ram_addr, 32'h100);
    chk("t2_ram_wd", ram_wd, 32'hAAAA);
    tick();
    settle();
    chk("t2_empty_we", {31'd0, ram_we}, 32'd0);
    tick();

    // 3: fill, overflow, FIFO drain order
    ram_ready = 1'b0;
    for (int k = 0; k < 4; k++) push(32'h10 + 32'(4 * k), 32'hD0 + 32'(k));
    settle();
    chk("t3_full", {31'd0, full}, 32'd1);
    chk("t3_no_ovf_yet", {31'd0, overflow}, 32'd0);
    tick();
    push(32'h20, 32'hEE);
    settle();
    chk("t3_overflow", {31'd0, overflow}, 32'd1);
    tick();
    ram_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("t3_drain_addr", ram_addr, 32'h10 + 32'(4 * k));
      chk("t3_drain_wd", ram_wd, 32'hD0 + 32'(k));
      tick();
    end
    settle();
    chk("t3_drained", {31'd0, ram_we}, 32'd0);
    tick();

    // 4: forwarding hit and miss, lookup blocks drain
    ram_ready = 1'b0;
    push(32'h40, 32'h1234);
    lookup_en = 1'b1; lookup_addr = 32'h40; ram_rd = 32'hDEAD;
    settle();
    chk("t4_fwd_hit", {31'd0, fwd_hit}, 32'd1);
    chk("t4_fill", fill_data, 32'h1234);
    chk("t4_we_blocked", {31'd0, ram_we}, 32'd0);
    tick();
    lookup_addr = 32'h44;
    settle();
    chk("t4_miss_hit", {31'd0, fwd_hit}, 32'd0);
    chk("t4_miss_fill", fill_data, 32'hDEAD);
    chk("t4_miss_addr", ram_addr, 32'h44);
    tick();
    lookup_en = 1'b0; ram_ready = 1'b1;
    tick();
    settle();
    chk("t4_drained", {31'd0, ram_we}, 32'd0);
    tick();

    // 5: coalescing within the same word
    ram_ready = 1'b0;
    push(32'h80, 32'h1);
    push(32'h83, 32'h2);
    settle();
    chk("t5_addr", ram_addr, 32'h80);
    chk("t5_wd", ram_wd, 32'h2);
    tick();
    ram_ready = 1'b1;
    tick();
    settle();
    chk("t5_single_entry", {31'd0, ram_we}, 32'd0);
    tick();

    // same-cycle push and lookup: lookup sees only prior entries
    ram_ready = 1'b0;
    push_en = 1'b1; push_addr = 32'hC0; push_data = 32'h5A;
    lookup_en = 1'b1; lookup_addr = 32'hC0; ram_rd = 32'h77;
    settle();
    chk("sc_no_fwd", {31'd0, fwd_hit}, 32'd0);
    chk("sc_fill", fill_data, 32'h77);
    tick();
    push_en = 1'b0;
    settle();
    chk("sc_next_fwd", fill_data, 32'h5A);
    tick();
    lookup_en = 1'b0;

    // 6: push while full and popping, then reset mid-drain
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) push(32'hA0 + 32'(4 * k), 32'hB0 + 32'(k));
    ram_ready = 1'b1;
    push(32'h90, 32'h99);
    ram_ready = 1'b0;
    settle();
    chk("t6_full", {31'd0, full}, 32'd1);
    chk("t6_no_ovf", {31'd0, overflow}, 32'd0);
    chk("t6_head", ram_addr, 32'hA4);
    tick();
    ram_ready = 1'b1;
    tick();
    rst = 1'b1;
    settle();
    chk("t6_rst_we", {31'd0, ram_we}, 32'd0);
    tick();
    rst = 1'b0;
    lookup_en = 1'b1; lookup_addr = 32'hA8; ram_rd = 32'h3C3C;
    settle();
    chk("t6_post_full", {31'd0, full}, 32'd0);
    chk("t6_post_hit", {31'd0, fwd_hit}, 32'd0);
    tick();
    lookup_en = 1'b0;
    settle();
    chk("t6_post_we", {31'd0, ram_we}, 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
